// File: rtl/dma_xfer_pkg.sv
// Shared types and constants for the DMA loopback transfer controller.
package dma_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CL_BYTES      = 64;
  localparam int CL_ADDR_SHIFT = 6;

  // One extra bit so the counter can hold the full depth, not just depth-1.
  function automatic int credit_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dma_line_fifo.sv
// Cache-line FIFO between the read-response and write-request channels.
// The head is a register: a pushed line becomes visible one cycle after the push.
module dma_line_fifo #(
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH      = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   data,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      rd_ptr_nxt;
  logic                  do_push;
  logic                  do_pop;

  assign empty      = (count == '0);
  assign full       = (count == CNT_W'(DEPTH));
  assign do_push    = push & ~full;
  assign do_pop     = pop & ~empty;
  assign rd_ptr_nxt = rd_ptr + PTR_W'(do_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      data   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr_nxt;
      count  <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      // The incoming line becomes the head only when it lands in the head slot.
      if (do_push && (wr_ptr == rd_ptr_nxt)) data <= push_data;
      else                                   data <= mem[rd_ptr_nxt];
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are valid, so clearing them is enough to flush the FIFO.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dma_xfer_ctrl.sv
// DMA loopback controller: reads `size` lines from rd_addr, buffers them, and
// writes them back to wr_addr; completion is signalled once every write is acked.
module dma_xfer_ctrl
  import dma_xfer_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 17,
  parameter int DATA_WIDTH = 512,
  parameter int BUF_DEPTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [SIZE_WIDTH-1:0] size,
  output logic                  done,
  output logic                  rd_req_valid,
  output logic [ADDR_WIDTH-1:0] rd_req_addr,
  input  logic                  rd_req_ready,
  input  logic                  rd_rsp_valid,
  input  logic [DATA_WIDTH-1:0] rd_rsp_data,
  output logic                  wr_req_valid,
  output logic [ADDR_WIDTH-1:0] wr_req_addr,
  output logic [DATA_WIDTH-1:0] wr_req_data,
  input  logic                  wr_req_ready,
  input  logic                  wr_rsp_valid
);

  localparam int CRD_W = credit_width(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  state_t                state;
  state_t                state_d;
  logic                  done_d;
  logic                  go_q;
  logic                  start;
  logic                  start_ok;
  logic                  running;

  logic [ADDR_WIDTH-1:0] rd_base;
  logic [ADDR_WIDTH-1:0] wr_base;
  logic [SIZE_WIDTH-1:0] size_q;
  logic [SIZE_WIDTH-1:0] rd_cnt;
  logic [SIZE_WIDTH-1:0] wr_cnt;
  logic [SIZE_WIDTH-1:0] ack_cnt;
  logic [SIZE_WIDTH-1:0] ack_cnt_d;
  logic [CRD_W-1:0]      credits;

  logic                  rd_fire;
  logic                  wr_fire;
  logic                  ack_fire;
  logic                  push;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CNT_W-1:0]      fifo_count;
  logic [DATA_WIDTH-1:0] fifo_data;

  assign start    = go & ~go_q;
  assign start_ok = start & (state != RUN);
  assign running  = (state == RUN);

  assign rd_req_valid = running & (rd_cnt < size_q) & (credits != '0);
  assign rd_req_addr  = rd_base + ADDR_WIDTH'(rd_cnt);
  assign wr_req_valid = running & ~fifo_empty;
  assign wr_req_addr  = wr_base + ADDR_WIDTH'(wr_cnt);
  assign wr_req_data  = fifo_data;

  assign rd_fire   = rd_req_valid & rd_req_ready;
  assign wr_fire   = wr_req_valid & wr_req_ready;
  assign ack_fire  = wr_rsp_valid & running;
  assign push      = rd_rsp_valid & running & ~fifo_full;
  assign ack_cnt_d = ack_cnt + SIZE_WIDTH'(ack_fire);

  dma_line_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (rd_rsp_data),
    .pop       (wr_fire),
    .data      (fifo_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        done_d = (state == DONE);
        if (start) begin
          state_d = (size == '0) ? DONE : RUN;
          done_d  = 1'b0;
        end
      end
      RUN: begin
        if (ack_fire && (ack_cnt_d == size_q)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      done    <= 1'b0;
      go_q    <= 1'b0;
      rd_base <= '0;
      wr_base <= '0;
      size_q  <= '0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      ack_cnt <= '0;
      credits <= '0;
    end else begin
      state <= state_d;
      done  <= done_d;
      go_q  <= go;
      if (start_ok) begin
        rd_base <= rd_addr;
        wr_base <= wr_addr;
        size_q  <= size;
        rd_cnt  <= '0;
        wr_cnt  <= '0;
        ack_cnt <= '0;
        credits <= CRD_W'(BUF_DEPTH);
      end else begin
        if (rd_fire)  rd_cnt  <= rd_cnt + SIZE_WIDTH'(1);
        if (wr_fire)  wr_cnt  <= wr_cnt + SIZE_WIDTH'(1);
        if (ack_fire) ack_cnt <= ack_cnt_d;
        // A read fire takes a buffer slot, a write fire returns one.
        unique case ({rd_fire, wr_fire})
          2'b10:   credits <= credits - CRD_W'(1);
          2'b01:   credits <= credits + CRD_W'(1);
          default: credits <= credits;
        endcase
      end
    end
  end

  // Credits bound the outstanding reads, so a response can never meet a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(rd_rsp_valid && running && fifo_full));

  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    !running || (({1'b0, credits} + {1'b0, fifo_count}) <= (CRD_W + 1)'(BUF_DEPTH)));

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Self-checking bench for dma_xfer_ctrl: memory/ack responders plus a
// line-by-line scoreboard of the expected read and write streams.
module tb_dma_xfer_ctrl;

  localparam int AW    = 64;
  localparam int SW    = 17;
  localparam int DW    = 512;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          go;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic [SW-1:0] size;
  logic          done;
  logic          rd_req_valid;
  logic [AW-1:0] rd_req_addr;
  logic          rd_req_ready;
  logic          rd_rsp_valid;
  logic [DW-1:0] rd_rsp_data;
  logic          wr_req_valid;
  logic [AW-1:0] wr_req_addr;
  logic [DW-1:0] wr_req_data;
  logic          wr_req_ready;
  logic          wr_rsp_valid;

  dma_xfer_ctrl #(
    .ADDR_WIDTH (AW),
    .SIZE_WIDTH (SW),
    .DATA_WIDTH (DW),
    .BUF_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .go           (go),
    .rd_addr      (rd_addr),
    .wr_addr      (wr_addr),
    .size         (size),
    .done         (done),
    .rd_req_valid (rd_req_valid),
    .rd_req_addr  (rd_req_addr),
    .rd_req_ready (rd_req_ready),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_data  (rd_rsp_data),
    .wr_req_valid (wr_req_valid),
    .wr_req_addr  (wr_req_addr),
    .wr_req_data  (wr_req_data),
    .wr_req_ready (wr_req_ready),
    .wr_rsp_valid (wr_rsp_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: line i reads rd_base+i, writes wr_base+i with the data of response i.
  logic [AW-1:0] rd_base_m;
  logic [AW-1:0] wr_base_m;
  int            rd_idx;
  int            wr_idx;
  int            acks_seen;
  int            done_rises;
  logic          done_prev = 1'b0;
  bit            model_on  = 1'b0;
  bit            rnd       = 1'b0;
  bit            wr_hold   = 1'b0;
  int            cyc       = 0;
  int            rd_due_q[$];
  int            ack_due_q[$];
  logic [DW-1:0] exp_data_q[$];
  logic [AW-1:0] rd_log[$];
  bit            hold_pending = 1'b0;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_data;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One clock: drive responses and readies at the falling edge, then score the
  // handshakes that will complete at the next rising edge.
  task automatic step();
    int            extra;
    logic [AW-1:0] exp_a;
    @(negedge clk);
    cyc++;
    rd_rsp_valid = 1'b0;
    if (rd_due_q.size() > 0 && rd_due_q[0] <= cyc) begin
      void'(rd_due_q.pop_front());
      rd_rsp_valid = 1'b1;
      rd_rsp_data  = rand_line();
      if (model_on) exp_data_q.push_back(rd_rsp_data);
    end
    wr_rsp_valid = 1'b0;
    if (ack_due_q.size() > 0 && ack_due_q[0] <= cyc) begin
      void'(ack_due_q.pop_front());
      wr_rsp_valid = 1'b1;
      if (model_on) acks_seen++;
    end
    rd_req_ready = rnd ? ($urandom_range(0, 99) < 60) : 1'b1;
    wr_req_ready = wr_hold ? 1'b0 : (rnd ? ($urandom_range(0, 99) < 60) : 1'b1);

    if (done && !done_prev) done_rises++;
    done_prev = done;

    if (hold_pending) begin
      check("wr_hold_valid", wr_req_valid, 1);
      check("wr_hold_addr", wr_req_addr, hold_addr);
      check("wr_hold_data", wr_req_data, hold_data);
    end
    hold_pending = wr_req_valid && !wr_req_ready;
    hold_addr    = wr_req_addr;
    hold_data    = wr_req_data;

    if (rd_req_valid && rd_req_ready) begin
      exp_a = rd_base_m + rd_idx;
      check("rd_req_addr", rd_req_addr, exp_a);
      rd_log.push_back(rd_req_addr);
      rd_idx++;
      extra = rnd ? int'($urandom_range(0, 3)) : 0;
      rd_due_q.push_back(cyc + 1 + extra);
    end
    if (wr_req_valid && wr_req_ready) begin
      exp_a = wr_base_m + wr_idx;
      check("wr_req_addr", wr_req_addr, exp_a);
      check("wr_has_line", exp_data_q.size() != 0, 1);
      if (exp_data_q.size() != 0) check("wr_req_data", wr_req_data, exp_data_q.pop_front());
      wr_idx++;
      extra = rnd ? int'($urandom_range(0, 3)) : 0;
      ack_due_q.push_back(cyc + 1 + extra);
    end
  endtask

  task automatic start_xfer(input logic [AW-1:0] ra, input logic [AW-1:0] wa, input int sz);
    rd_base_m  = ra;
    wr_base_m  = wa;
    rd_idx     = 0;
    wr_idx     = 0;
    acks_seen  = 0;
    done_rises = 0;
    model_on   = 1'b1;
    exp_data_q.delete();
    rd_log.delete();
    rd_addr = ra;
    wr_addr = wa;
    size    = SW'(sz);
    go      = 1'b1;
    step();
    check("done_drop", done, 0);
    check("rd_valid_first", rd_req_valid, sz != 0);
  endtask

  task automatic wait_done(input string tag, input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    check(tag, done, 1);
  endtask

  task automatic finish_xfer(input int sz);
    check("rd_lines", rd_idx, sz);
    check("wr_lines", wr_idx, sz);
    check("acks", acks_seen, sz);
    check("sb_empty", exp_data_q.size(), 0);
    go = 1'b0;
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (rd_due_q.size() + ack_due_q.size()) != 0; i++) step();
    check("drain", rd_due_q.size() + ack_due_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_valid"}, rd_req_valid, 0);
    check({tag, "_wr_valid"}, wr_req_valid, 0);
    check({tag, "_rd_addr"}, rd_req_addr, 0);
    check({tag, "_wr_addr"}, wr_req_addr, 0);
    check({tag, "_wr_data"}, wr_req_data, 0);
  endtask

  initial begin
    int n;
    int bad;
    rst = 1'b1; go = 1'b0; rd_addr = '0; wr_addr = '0; size = '0;
    rd_req_ready = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_data = '0;
    wr_req_ready = 1'b0; wr_rsp_valid = 1'b0;
    repeat (3) step();
    check_outputs_zero("reset");
    rst = 1'b0;
    step();

    // Zero-length transfer: no requests, done two cycles after go rises.
    start_xfer(64'h100, 64'h200, 0);
    step();
    check("zero_done", done, 1);
    check("zero_no_req", rd_idx + wr_idx, 0);
    finish_xfer(0);

    // Single line, everything ready: minimum latency.
    start_xfer(64'h10, 64'h20, 1);
    wait_done("lat_done", 20, n);
    check("lat_1line", 1 + n, 5);
    finish_xfer(1);

    // Four lines, always ready.
    start_xfer(64'h1000, 64'h2000, 4);
    wait_done("four_done", 100, n);
    finish_xfer(4);

    // Write channel stalled: reads stop once the buffer credits run out.
    wr_hold = 1'b1;
    start_xfer(64'h5000, 64'h6000, 16);
    repeat (49) step();
    check("stall_rd_fires", rd_idx, DEPTH);
    check("stall_rd_valid", rd_req_valid, 0);
    check("stall_wr_valid", wr_req_valid, 1);
    wr_hold = 1'b0;
    wait_done("stall_done", 500, n);
    finish_xfer(16);

    // Random stalls and memory latency on both channels.
    rnd = 1'b1;
    start_xfer({$urandom, $urandom}, {$urandom, $urandom}, 100);
    wait_done("rand_done", 3000, n);
    repeat (5) step();
    check("rand_done_once", done_rises, 1);
    check("rand_done_held", done, 1);
    finish_xfer(100);
    rnd = 1'b0;

    // Reset mid-transfer, then a fresh transfer.
    start_xfer(64'h3000, 64'h4000, 8);
    n = 0;
    while (acks_seen < 3 && n < 100) begin
      step();
      n++;
    end
    check("abort_progress", acks_seen >= 3, 1);
    rst = 1'b1;
    go = 1'b0;
    model_on = 1'b0;
    hold_pending = 1'b0;
    step();
    check_outputs_zero("abort");
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rd_req_valid || wr_req_valid || done) bad++;
    end
    check("abort_idle", bad, 0);
    drain();
    start_xfer(64'h40, 64'h80, 2);
    wait_done("restart_done", 100, n);
    finish_xfer(2);

    // Source address wraps past the top of the address space.
    start_xfer(64'hFFFF_FFFF_FFFF_FFFE, 64'h7000, 4);
    wait_done("wrap_done", 100, n);
    check("wrap_a0", rd_log[0], 64'hFFFF_FFFF_FFFF_FFFE);
    check("wrap_a1", rd_log[1], 64'hFFFF_FFFF_FFFF_FFFF);
    check("wrap_a2", rd_log[2], 64'h0);
    check("wrap_a3", rd_log[3], 64'h1);
    finish_xfer(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dma_xfer_ctrl.md
Name: dma_xfer_ctrl

Overview:
Sequences one DMA loopback transfer of `size` cache lines from `rd_addr` to `wr_addr`. It takes its configuration and `go`/`done` from the MMIO memory map and issues one read request per line. Read responses are buffered in an internal FIFO and replayed as write requests. The block counts write acknowledgements to detect completion and sits between the memory map and the DMA read/write channels.

Parameters:
ADDR_WIDTH, 64, width of cache-line addresses (byte address >> 6; conversion is done outside this block).
SIZE_WIDTH, 17, width of the line count; maximum transfer is 2**SIZE_WIDTH-1 lines.
DATA_WIDTH, 512, cache-line width.
BUF_DEPTH, 64, FIFO depth in lines; power of 2, at least 2.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
go  in  1  start request, level-held by the memory map
rd_addr  in  ADDR_WIDTH  source base line address
wr_addr  in  ADDR_WIDTH  destination base line address
size  in  SIZE_WIDTH  number of lines
done  out  1  transfer complete
rd_req_valid  out  1  read request valid
rd_req_addr  out  ADDR_WIDTH  read line address
rd_req_ready  in  1  read channel accepts
rd_rsp_valid  in  1  read data returned (in order, no backpressure)
rd_rsp_data  in  DATA_WIDTH  read data
wr_req_valid  out  1  write request valid
wr_req_addr  out  ADDR_WIDTH  write line address
wr_req_data  out  DATA_WIDTH  write data
wr_req_ready  in  1  write channel accepts
wr_rsp_valid  in  1  one write acknowledged

Behaviour:
- Reset (synchronous, active-high) clears all outputs and internal state:
  - done=0, rd_req_valid=0, wr_req_valid=0, both address outputs=0, wr_req_data=0.
  - FIFO is flushed, all counters=0, go_q=0, state=IDLE.
  - Asserting reset mid-transfer aborts the transfer. Responses arriving after reset are ignored.
- Start condition: start = go & ~go_q, where go_q is a 1-cycle delayed copy of go.
  - go held high through reset release starts a transfer in the first cycle after reset.
- FSM states: IDLE, RUN, DONE.
  - IDLE and DONE: on start, latch rd_addr, wr_addr and size. Clear rd_cnt, wr_cnt and ack_cnt. Set credits=BUF_DEPTH. Clear done. Go to RUN. If size==0, go directly to DONE instead.
  - RUN: go to DONE in the cycle ack_cnt reaches size. done=1 from the following cycle.
  - DONE: done is held at 1 until the next start. done drops in the cycle after start is seen.
  - start is ignored while in RUN.
- Read issue:
  - rd_req_valid = RUN & (rd_cnt < size) & (credits != 0).
  - rd_req_addr = rd_base + rd_cnt.
  - On fire (valid & ready): rd_cnt++ and credits--.
  - rd_req_valid is first asserted 1 cycle after start.
- Credits (width clog2(BUF_DEPTH)+1):
  - Incremented on each write fire.
  - A simultaneous read fire and write fire leaves credits unchanged.
  - Credits guarantee the FIFO can never overflow, so rd_rsp_valid is always accepted.
  - rd_rsp_valid while the FIFO is full is a simulation assertion error.
- FIFO:
  - Push on rd_rsp_valid during RUN.
  - Registered output with no bypass: pushed data is visible at the FIFO head on the next cycle.
- Write issue:
  - wr_req_valid = RUN & ~fifo_empty.
  - wr_req_data = FIFO head.
  - wr_req_addr = wr_base + wr_cnt.
  - On fire: pop the FIFO and wr_cnt++.
  - wr_req_valid, wr_req_addr and wr_req_data stay stable while valid & ~ready.
- Acknowledgements: ack_cnt++ on wr_rsp_valid in RUN. wr_rsp_valid outside RUN is ignored.
- Arithmetic:
  - Address sums are modulo 2**ADDR_WIDTH; wrap-around is permitted and not flagged.
  - All counters are SIZE_WIDTH bits.
- Minimum latency:
  - 1-line transfer with always-ready channels and 1-cycle memory: done rises 5 cycles after start.

Decomposition:
- Package dma_xfer_pkg holds:
  - state_t enum {IDLE, RUN, DONE};
  - CL_BYTES=64 and CL_ADDR_SHIFT=6;
  - a credit-width function, clog2(depth)+1.
- Sub-module dma_line_fifo (parameters DATA_WIDTH and DEPTH) provides:
  - push/pop/data/empty/full and a count output;
  - synchronous reset that flushes contents.

Test Plan:
- size=0, go 0->1: no rd_req or wr_req issued; done=1 two cycles after go rises.
- rd_addr=0x1000, wr_addr=0x2000, size=4, channels always ready, 1-cycle memory: rd_req_addr 0x1000..0x1003 and wr_req_addr 0x2000..0x2003 in order; write data equals read data per line; done after the 4th ack.
- BUF_DEPTH=4, size=16, wr_req_ready held 0 for 50 cycles: exactly 4 rd_req fires, then rd_req_valid=0; no FIFO-full assertion; after release all 16 lines complete and done=1.
- Random ready/valid stalls on both channels, size=100: scoreboard matches every data/address pair; done exactly once.
- rst asserted after 3 of 8 lines: all outputs return to 0 next cycle; later acks ignored; a new go with size=2 completes correctly.
- rd_addr=2**64-2, size=4: read addresses 0x...FE, 0x...FF, 0x0, 0x1; done=1.
